// File: rtl/mcs4_pkg.sv
// MCS-4 bus sequencer shared definitions.
// Subcycle indices and phase vector width.
package mcs4_pkg;

  localparam int PHASE_W = 8;

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A2 = 3'd1;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X1 = 3'd5;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

endpackage

// File: rtl/mcs4_phase_gen.sv
// MCS-4 phase generator: tick counter, subcycle,
// two-phase clocks and one-hot subcycle vector.
module mcs4_phase_gen
  import mcs4_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic               sysclk,
  input  logic               poc_n,
  input  logic               en,
  output logic               running,
  output logic [2:0]         sub,
  output logic               last,
  output logic               clk1,
  output logic               clk2,
  output logic [PHASE_W-1:0] phase
);

  localparam int TW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(2 * DIV - 1);
  localparam logic [TW-1:0] TDIV = TW'(DIV);

  logic [TW-1:0] tc;

  // First edge after reset only arms the sequencer.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      running <= 1'b0;
      tc      <= '0;
      sub     <= SC_A1;
    end else if (!running) begin
      running <= 1'b1;
    end else if (en) begin
      if (tc == TMAX) begin
        tc  <= '0;
        sub <= sub + 3'd1;
      end else begin
        tc <= tc + 1'b1;
      end
    end
  end

  assign last  = running && (tc == TMAX);
  assign clk1  = running && (tc < TDIV);
  assign clk2  = running && (tc >= TDIV);
  assign phase = running ? (PHASE_W'(1) << sub) : '0;

endmodule

// File: rtl/mcs4_bus_sequencer.sv
// MCS-4 instruction-cycle bus sequencer.
// Drives address, captures opcode, handles I/O.
module mcs4_bus_sequencer
  import mcs4_pkg::*;
#(
  parameter int DW   = 4,
  parameter int NRAM = 4,
  parameter int DIV  = 1,
  localparam int BW  = (NRAM > 1) ? $clog2(NRAM) : 1
) (
  input  logic               sysclk,
  input  logic               poc_n,
  input  logic               en,
  input  logic [3*DW-1:0]    pc,
  input  logic               io_op,
  input  logic               io_dir,
  input  logic [DW-1:0]      io_wdata,
  input  logic [BW-1:0]      ram_bank,
  input  logic [DW-1:0]      data_in,
  output logic [DW-1:0]      data_out,
  output logic               data_dir,
  output logic               clk1,
  output logic               clk2,
  output logic [PHASE_W-1:0] phase,
  output logic               sync,
  output logic               cmrom,
  output logic [NRAM-1:0]    cmram,
  output logic [DW-1:0]      opr,
  output logic [DW-1:0]      opa,
  output logic               instr_valid,
  output logic               io_rvalid,
  output logic [DW-1:0]      io_rdata
);

  logic          running;
  logic          last;
  logic [2:0]    sub;
  logic          step;
  logic          s_op;
  logic          s_dir;
  logic [DW-1:0] s_wdata;
  logic [BW-1:0] s_bank;
  logic          use_bank;
  logic [BW-1:0] bank_sel;

  mcs4_phase_gen #(.DIV(DIV)) u_phase (
    .sysclk  (sysclk),
    .poc_n   (poc_n),
    .en      (en),
    .running (running),
    .sub     (sub),
    .last    (last),
    .clk1    (clk1),
    .clk2    (clk2),
    .phase   (phase)
  );

  assign step = running && en && last;

  // Captures happen on the last tick of a subcycle.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      opr         <= '0;
      opa         <= '0;
      io_rdata    <= '0;
      instr_valid <= 1'b0;
      io_rvalid   <= 1'b0;
      s_op        <= 1'b0;
      s_dir       <= 1'b0;
      s_wdata     <= '0;
      s_bank      <= '0;
    end else begin
      instr_valid <= 1'b0;
      io_rvalid   <= 1'b0;
      if (step) begin
        case (sub)
          SC_M1: begin
            opr     <= data_in;
            s_op    <= io_op;
            s_dir   <= io_dir;
            s_wdata <= io_wdata;
            s_bank  <= ram_bank;
          end
          SC_M2: begin
            opa         <= data_in;
            instr_valid <= 1'b1;
          end
          SC_X2: begin
            if (s_op && !s_dir) begin
              io_rdata  <= data_in;
              io_rvalid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_out = '0;
    data_dir = 1'b0;
    cmrom    = 1'b0;
    cmram    = '0;
    sync     = 1'b0;
    use_bank = 1'b0;
    bank_sel = ram_bank;
    if (running) begin
      case (sub)
        SC_A1: begin
          data_dir = 1'b1;
          data_out = pc[DW-1:0];
        end
        SC_A2: begin
          data_dir = 1'b1;
          data_out = pc[2*DW-1:DW];
        end
        SC_A3: begin
          data_dir = 1'b1;
          data_out = pc[3*DW-1:2*DW];
          cmrom    = 1'b1;
          use_bank = 1'b1;
        end
        SC_M2: begin
          if (s_op) begin
            cmrom    = 1'b1;
            use_bank = 1'b1;
            bank_sel = s_bank;
          end
        end
        SC_X2: begin
          if (s_op && s_dir) begin
            data_dir = 1'b1;
            data_out = s_wdata;
          end
        end
        SC_X3: sync = 1'b1;
        default: ;
      endcase
    end
    // Out-of-range banks match no line.
    for (int i = 0; i < NRAM; i++) begin
      if (use_bank && bank_sel == BW'(i)) cmram[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Bench for mcs4_bus_sequencer (DW=4, NRAM=4, DIV=1).
// Table-driven write cycle plus directed corner cases.
module tb_mcs4_bus_sequencer;

  logic        sysclk = 1'b0;
  logic        poc_n;
  logic        en;
  logic [11:0] pc;
  logic        io_op;
  logic        io_dir;
  logic [3:0]  io_wdata;
  logic [1:0]  ram_bank;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        data_dir;
  logic        clk1;
  logic        clk2;
  logic [7:0]  phase;
  logic        sync;
  logic        cmrom;
  logic [3:0]  cmram;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic        instr_valid;
  logic        io_rvalid;
  logic [3:0]  io_rdata;

  int errors = 0;
  int checks = 0;
  int cnt;

  always #5 sysclk = ~sysclk;

  mcs4_bus_sequencer #(.DW(4), .NRAM(4), .DIV(1)) dut (
    .sysclk      (sysclk),
    .poc_n       (poc_n),
    .en          (en),
    .pc          (pc),
    .io_op       (io_op),
    .io_dir      (io_dir),
    .io_wdata    (io_wdata),
    .ram_bank    (ram_bank),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_dir    (data_dir),
    .clk1        (clk1),
    .clk2        (clk2),
    .phase       (phase),
    .sync        (sync),
    .cmrom       (cmrom),
    .cmram       (cmram),
    .opr         (opr),
    .opa         (opa),
    .instr_valid (instr_valid),
    .io_rvalid   (io_rvalid),
    .io_rdata    (io_rdata)
  );

  typedef struct {
    logic [3:0] din;
    logic [7:0] ph;
    logic       c1;
    logic       c2;
    logic [3:0] dout;
    logic       dir;
    logic       rom;
    logic [3:0] ram;
    logic       syn;
    logic       iv;
    logic [3:0] op_r;
    logic [3:0] op_a;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input int t,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h",
               nm, t, act, exp);
    end
  endtask

  task automatic go();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{4'h0, 8'h01, 1, 0, 4'hC, 1, 0, 4'h0, 0, 0, 4'h0, 4'h0};
    vt[1]  = '{4'h0, 8'h01, 0, 1, 4'hC, 1, 0, 4'h0, 0, 0, 4'h0, 4'h0};
    vt[2]  = '{4'h0, 8'h02, 1, 0, 4'hB, 1, 0, 4'h0, 0, 0, 4'h0, 4'h0};
    vt[3]  = '{4'h0, 8'h02, 0, 1, 4'hB, 1, 0, 4'h0, 0, 0, 4'h0, 4'h0};
    vt[4]  = '{4'h0, 8'h04, 1, 0, 4'hA, 1, 1, 4'h4, 0, 0, 4'h0, 4'h0};
    vt[5]  = '{4'h0, 8'h04, 0, 1, 4'hA, 1, 1, 4'h4, 0, 0, 4'h0, 4'h0};
    vt[6]  = '{4'h5, 8'h08, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0};
    vt[7]  = '{4'h5, 8'h08, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0};
    vt[8]  = '{4'h9, 8'h10, 1, 0, 4'h0, 0, 1, 4'h4, 0, 0, 4'h5, 4'h0};
    vt[9]  = '{4'h9, 8'h10, 0, 1, 4'h0, 0, 1, 4'h4, 0, 0, 4'h5, 4'h0};
    vt[10] = '{4'h0, 8'h20, 1, 0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h5, 4'h9};
    vt[11] = '{4'h0, 8'h20, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 4'h5, 4'h9};
    vt[12] = '{4'h0, 8'h40, 1, 0, 4'h7, 1, 0, 4'h0, 0, 0, 4'h5, 4'h9};
    vt[13] = '{4'h0, 8'h40, 0, 1, 4'h7, 1, 0, 4'h0, 0, 0, 4'h5, 4'h9};
    vt[14] = '{4'h0, 8'h80, 1, 0, 4'h0, 0, 0, 4'h0, 1, 0, 4'h5, 4'h9};
    vt[15] = '{4'h0, 8'h80, 0, 1, 4'h0, 0, 0, 4'h0, 1, 0, 4'h5, 4'h9};

    poc_n    = 1'b0;
    en       = 1'b1;
    pc       = 12'hABC;
    io_op    = 1'b1;
    io_dir   = 1'b1;
    io_wdata = 4'h7;
    ram_bank = 2'd2;
    data_in  = 4'h0;

    // Reset state
    repeat (3) @(negedge sysclk);
    chk("rst_phase", 0, phase, 8'h00);
    chk("rst_clk1", 0, clk1, 1'b0);
    chk("rst_clk2", 0, clk2, 1'b0);
    chk("rst_dir", 0, data_dir, 1'b0);
    chk("rst_dout", 0, data_out, 4'h0);
    chk("rst_sync", 0, sync, 1'b0);
    chk("rst_cm", 0, {cmrom, cmram}, 5'h00);
    chk("rst_opr", 0, opr, 4'h0);
    poc_n = 1'b1;
    go();

    // Cycle 1: table-driven write cycle
    for (int t = 0; t < 16; t++) begin
      if (t > 0) go();
      data_in = vt[t].din;
      @(negedge sysclk);
      chk("c1_phase", t, phase, vt[t].ph);
      chk("c1_clks", t, {clk1, clk2}, {vt[t].c1, vt[t].c2});
      chk("c1_dout", t, data_out, vt[t].dout);
      chk("c1_dir", t, data_dir, vt[t].dir);
      chk("c1_cmrom", t, cmrom, vt[t].rom);
      chk("c1_cmram", t, cmram, vt[t].ram);
      chk("c1_sync", t, sync, vt[t].syn);
      chk("c1_ivalid", t, instr_valid, vt[t].iv);
      chk("c1_opr", t, opr, vt[t].op_r);
      chk("c1_opa", t, opa, vt[t].op_a);
      chk("c1_rvalid", t, io_rvalid, 1'b0);
    end

    // Cycle 2: read cycle; late io changes ignored
    for (int t = 0; t < 16; t++) begin
      go();
      if (t == 0) begin
        io_op = 1'b1;
        io_dir = 1'b0;
        ram_bank = 2'd1;
      end
      if (t == 10) begin
        io_dir = 1'b1;
        ram_bank = 2'd3;
      end
      data_in = (t == 6 || t == 7) ? 4'h2 :
                (t == 8 || t == 9) ? 4'h1 :
                (t == 12 || t == 13) ? 4'h3 : 4'h0;
      @(negedge sysclk);
      if (t == 4) chk("c2_a3_cmram", t, cmram, 4'b0010);
      if (t == 8 || t == 9)
        chk("c2_m2_cmram", t, {cmrom, cmram}, 5'h12);
      if (t == 10) chk("c2_opcode", t, {opr, opa}, 8'h21);
      if (t == 12 || t == 13)
        chk("c2_x2_dir", t, {data_dir, data_out}, 5'h00);
      if (t == 14)
        chk("c2_rdata", t, {io_rvalid, io_rdata}, 5'h13);
      if (t == 15) chk("c2_rvalid_off", t, io_rvalid, 1'b0);
    end

    // Cycle 3: en=0 for 5 ticks in M1
    io_op = 1'b0;
    for (int t = 0; t < 6; t++) begin
      go();
      data_in = 4'h0;
      @(negedge sysclk);
    end
    for (int t = 6; t < 11; t++) begin
      go();
      en = 1'b0;
      data_in = 4'hF;
      @(negedge sysclk);
      chk("c3_frz_phase", t, phase, 8'h08);
      chk("c3_frz_clks", t, {clk1, clk2}, 2'b10);
      chk("c3_frz_opr", t, opr, 4'h2);
    end
    go();
    en = 1'b1;
    data_in = 4'h6;
    @(negedge sysclk);
    chk("c3_resume", 11, {phase, clk1}, 9'h011);
    cnt = 11;
    do begin
      go();
      cnt++;
      @(negedge sysclk);
    end while (phase != 8'h01 && cnt < 40);
    chk("c3_length", cnt, cnt, 21);
    chk("c3_opcode", cnt, {opr, opa}, 8'h66);

    // Cycle 4: pulse drops under freeze, then reset in X2
    io_op = 1'b1;
    io_dir = 1'b1;
    io_wdata = 4'h7;
    ram_bank = 2'd0;
    data_in = 4'h0;
    for (int t = 1; t <= 10; t++) begin
      go();
      @(negedge sysclk);
    end
    chk("c4_ivalid", 10, instr_valid, 1'b1);
    en = 1'b0;
    go();
    en = 1'b1;
    @(negedge sysclk);
    chk("c4_iv_drop", 11, instr_valid, 1'b0);
    chk("c4_frz_phase", 11, {phase, clk1}, 9'h041);
    cnt = 0;
    do begin
      go();
      cnt++;
      @(negedge sysclk);
    end while (phase != 8'h40 && cnt < 10);
    chk("c4_x2_phase", cnt, phase, 8'h40);
    chk("c4_x2_drive", cnt, {data_dir, data_out}, 5'h17);
    #1 poc_n = 1'b0;
    #1;
    chk("rst_x2_dir", 0, {data_dir, data_out}, 5'h00);
    chk("rst_x2_phase", 0, phase, 8'h00);
    chk("rst_x2_clks", 0, {clk1, clk2}, 2'b00);
    chk("rst_x2_regs", 0, {opr, opa}, 8'h00);
    @(negedge sysclk);
    poc_n = 1'b1;
    go();
    @(negedge sysclk);
    chk("post_rst_phase", 0, {phase, clk1}, 9'h003);
    chk("post_rst_bus", 0, {data_dir, data_out}, 5'h1C);
    chk("post_rst_pulse", 0, {instr_valid, io_rvalid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcs4_bus_sequencer.md
MCS4_BUS_SEQUENCER -- requirements
Module: mcs4_bus_sequencer

Interface
REQ-001 Parameter DW, default 4: data bus width in bits; legal values 4 and 8.
REQ-002 Parameter NRAM, default 4: number of CM-RAM lines, from 1 to 8.
REQ-003 Parameter DIV, default 1: sysclk ticks per clock phase, >=1; one subcycle = 2*DIV ticks.
REQ-004 Port sysclk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port poc_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port en, input, 1: advance enable; 0 freezes the sequencer.
REQ-007 Port pc, input, 3*DW: fetch address; low slice first on the bus.
REQ-008 Port io_op, input, 1: current instruction is an I/O or RAM op.
REQ-009 Port io_dir, input, 1: 1 = CPU drives in X2; 0 = CPU reads in X2.
REQ-010 Port io_wdata, input, DW: write data for X2.
REQ-011 Port ram_bank, input, clog2(NRAM) (min 1): CM-RAM line select.
REQ-012 Port data_in, input, DW: bus input.
REQ-013 Port data_out, output, DW: bus output value.
REQ-014 Port data_dir, output, 1: 1 = this block drives the bus.
REQ-015 Port clk1 and clk2, outputs, 1 each: non-overlapping phase clocks.
REQ-016 Port phase, output, 8: one-hot subcycle, bit0=A1 ... bit7=X3.
REQ-017 Port sync, cmrom, outputs, 1 each; port cmram, output, NRAM.
REQ-018 Port opr and opa, outputs, DW each: captured opcode nibbles.
REQ-019 Port instr_valid and io_rvalid, outputs, 1 each: single-tick pulses.
REQ-020 Port io_rdata, output, DW: X2 read data.

Function
REQ-021 Tick counter tc runs 0..2*DIV-1 and advances only when en=1; clk1 is high for tc<DIV, clk2 for tc>=DIV.
REQ-022 Subcycle order A1,A2,A3,M1,M2,X1,X2,X3, then A1; the subcycle advances when tc wraps; X3 wraps to A1.
REQ-023 Bus activity in A1/A2/A3: data_dir=1; data_out = pc[DW-1:0], pc[2DW-1:DW], pc[3DW-1:2DW] in that order; pc is used live, not sampled.
REQ-024 A3: cmrom=1 and cmram[ram_bank]=1; all other cmram bits 0.
REQ-025 M1 and M2: data_dir=0. Last tick of M1 loads opr<=data_in; last tick of M2 loads opa<=data_in.
REQ-026 instr_valid is high exactly one tick, on the tick after the opa load.
REQ-027 io_op, io_dir, io_wdata and ram_bank are sampled on the tick entering M2 and held to end of cycle; later input changes are ignored.
REQ-028 M2 with sampled io_op=1: cmrom=1 and cmram[sampled bank]=1.
REQ-029 X2 with io_op=1 and io_dir=1: data_dir=1 and data_out=io_wdata.
REQ-030 X2 with io_op=1 and io_dir=0: data_dir=0; io_rdata<=data_in on the last X2 tick; io_rvalid pulses one tick after that load.
REQ-031 All other subcycles: data_dir=0, data_out=0, cm lines 0.
REQ-032 sync=1 for the whole of X3, else 0.
REQ-033 en=0: tc, subcycle, clocks and all outputs hold; no capture occurs; a pulse already high still drops after one tick.
REQ-034 ram_bank >= NRAM: no cmram bit asserted; cmrom unaffected.

Reset
REQ-035 poc_n=0 immediately forces running=0, tc=0, subcycle=A1 and opr/opa/io_rdata=0.
REQ-036 While running=0, every output is 0, including phase, clk1, clk2 and data_dir.
REQ-037 The first sysclk edge after poc_n rises sets running=1 with no advance; the cycle starts at A1, tc=0, on that tick.
REQ-038 Reset mid-cycle abandons the cycle; no pulse and no bus drive survive it.

Structure
REQ-039 Shared package mcs4_pkg holds the subcycle index constants (A1=0..X3=7) and the phase-width constant.
REQ-040 One sub-module, mcs4_phase_gen, holds tc, subcycle, running, clk1/clk2 and phase; the datapath and capture logic stay in the top.

Verification
REQ-041 DIV=1, pc=12'hABC, en=1 -> data_out C,B,A on ticks 0-1, 2-3, 4-5 with data_dir=1; sync high on ticks 14-15; cycle length 16.
REQ-042 data_in=5 during M1 and 9 during M2 -> opr=5, opa=9; instr_valid high only at tick 10.
REQ-043 io_op=1, io_dir=1, io_wdata=7, ram_bank=2 -> cmram=4'b0100 in A3 and M2; data_out=7 with data_dir=1 during X2.
REQ-044 io_op=1, io_dir=0, data_in=3 in X2 -> io_rdata=3; one-tick io_rvalid; data_dir=0 throughout X2.
REQ-045 en=0 for 5 ticks mid-M1 -> all outputs frozen; the cycle resumes and completes with total length 21 ticks.
REQ-046 poc_n low during X2 write -> data_dir=0 at once; after release the first tick is A1 with data_out=pc[3:0].
